// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Two-flop synchronizer, press/release debounce FSM and
//               auto-repeat generator for a single raw pushbutton. Emits a
//               clean level, one-cycle press/release/repeat pulses and an
//               8-bit wrapping press counter. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    // Counter widths; a one-cycle debounce still needs a 1-bit counter.
    localparam int c_DCNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_RD_BITS  = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int c_RR_BITS  = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam int c_RCNT_W   = (c_RD_BITS > c_RR_BITS) ? c_RD_BITS : c_RR_BITS;
    localparam bit c_REPEAT_EN = (REPEAT_DELAY != 0);

    // Terminal counts, guarded so a zero delay does not underflow.
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST  = c_DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RCNT_W-1:0] c_DELAY_LAST =
        c_RCNT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [c_RCNT_W-1:0] c_RATE_LAST  =
        c_RCNT_W'((REPEAT_RATE > 0) ? (REPEAT_RATE - 1) : 0);

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_HELD         = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    logic                r_s1;
    logic                r_btn_s;
    logic [1:0]          r_state;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic [c_RCNT_W-1:0] r_rcnt;
    logic                r_first;

    logic [1:0]          w_state_nxt;
    logic [c_DCNT_W-1:0] w_dcnt_nxt;
    logic [c_RCNT_W-1:0] w_rcnt_nxt;
    logic                w_first_nxt;
    logic                w_level_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_repeat_nxt;
    logic [7:0]          w_count_nxt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_s1    <= btn_in;
            r_btn_s <= r_s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_dcnt        <= '0;
            r_rcnt        <= '0;
            r_first       <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_dcnt        <= w_dcnt_nxt;
            r_rcnt        <= w_rcnt_nxt;
            r_first       <= w_first_nxt;
            btn_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            repeat_pulse  <= w_repeat_nxt;
            press_count   <= w_count_nxt;
        end
    end

    // Next-state, debounce/repeat counting and next output values.
    always_comb begin
        w_state_nxt   = r_state;
        w_dcnt_nxt    = r_dcnt;
        w_rcnt_nxt    = r_rcnt;
        w_first_nxt   = r_first;
        w_level_nxt   = btn_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_count_nxt   = press_count;

        case (r_state)
            c_ST_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = c_ST_PRESS_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end

            c_ST_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_dcnt == c_DCNT_LAST) begin
                    w_state_nxt = c_ST_HELD;
                    w_press_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                    w_count_nxt = press_count + 8'd1;
                    w_rcnt_nxt  = '0;
                    w_first_nxt = 1'b0;
                end else begin
                    w_dcnt_nxt = r_dcnt + c_DCNT_W'(1);
                end
            end

            c_ST_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_ST_RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
                end
                // The repeat timer runs on every HELD cycle, including the
                // one that leaves for RELEASE_WAIT; it is frozen there.
                if (c_REPEAT_EN) begin
                    if (!r_first) begin
                        if (r_rcnt == c_DELAY_LAST) begin
                            w_repeat_nxt = 1'b1;
                            w_rcnt_nxt   = '0;
                            w_first_nxt  = 1'b1;
                        end else begin
                            w_rcnt_nxt = r_rcnt + c_RCNT_W'(1);
                        end
                    end else begin
                        if (r_rcnt == c_RATE_LAST) begin
                            w_repeat_nxt = 1'b1;
                            w_rcnt_nxt   = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + c_RCNT_W'(1);
                        end
                    end
                end
            end

            c_ST_RELEASE_WAIT: begin
                if (r_btn_s) begin
                    // Release bounce: resume HELD with the repeat timer intact.
                    w_state_nxt = c_ST_HELD;
                end else if (r_dcnt == c_DCNT_LAST) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_dcnt_nxt = r_dcnt + c_DCNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. Two instances
//               share the stimulus: one with auto-repeat, one with
//               REPEAT_DELAY=0. A cycle-level reference model derived from
//               the debounce/repeat rules is compared every cycle; a segment
//               table and hand sequences check the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_DEB = 4;
    localparam int c_RD  = 8;
    localparam int c_RR  = 3;
    localparam int c_NSEG = 18;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       btn_in = 1'b0;

    logic       a_level, a_press, a_release, a_repeat;
    logic [7:0] a_count;
    logic       b_level, b_press, b_release, b_repeat;
    logic [7:0] b_count;

    button_conditioner #(
        .DEBOUNCE_CYCLES(c_DEB), .REPEAT_DELAY(c_RD), .REPEAT_RATE(c_RR)
    ) u_dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(a_level), .press_pulse(a_press), .release_pulse(a_release),
        .repeat_pulse(a_repeat), .press_count(a_count)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(c_DEB), .REPEAT_DELAY(0), .REPEAT_RATE(c_RR)
    ) u_dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(b_level), .press_pulse(b_press), .release_pulse(b_release),
        .repeat_pulse(b_repeat), .press_count(b_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: two-stage input delay, accepted level, length
    // of the current run of samples disagreeing with the level, number of
    // HELD cycles since the press was accepted.
    bit m_s1, m_bs, m_level;
    bit m_press, m_release, m_repeat;
    int m_run, m_held, m_count;

    int obs_press, obs_release, obs_repeat, obs_b_press, obs_b_repeat;

    typedef struct {
        bit btn;
        int cycles;
        int press;
        int rel;
        int rep;
        bit level;
        int count;
    } seg_t;

    seg_t segs [0:c_NSEG-1];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_bs = 0; m_level = 0;
        m_press = 0; m_release = 0; m_repeat = 0;
        m_run = 0; m_held = 0; m_count = 0;
    endtask

    task automatic model_edge(input bit b);
        bit seen;
        bit in_held;
        seen = m_bs;
        m_bs = m_s1;
        m_s1 = b;
        m_press = 0; m_release = 0; m_repeat = 0;
        in_held = m_level && (m_run == 0);
        if (seen != m_level) m_run++;
        else m_run = 0;
        if (in_held) begin
            m_held++;
            if (m_held == c_RD || (m_held > c_RD && (m_held - c_RD) % c_RR == 0))
                m_repeat = 1;
        end
        if (m_run == c_DEB + 1) begin
            m_run = 0;
            if (!m_level) begin
                m_level = 1; m_press = 1; m_held = 0;
                m_count = (m_count + 1) % 256;
            end else begin
                m_level = 0; m_release = 1;
            end
        end
    endtask

    // One clock: drive, let the edge happen, compare both DUTs at negedge.
    task automatic cycle(input bit b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        check("a_level",   a_level,   m_level);
        check("a_press",   a_press,   m_press);
        check("a_release", a_release, m_release);
        check("a_repeat",  a_repeat,  m_repeat);
        check("a_count",   a_count,   m_count);
        check("b_level",   b_level,   m_level);
        check("b_press",   b_press,   m_press);
        check("b_release", b_release, m_release);
        check("b_repeat",  b_repeat,  0);
        check("b_count",   b_count,   m_count);
        obs_press    += a_press;
        obs_release  += a_release;
        obs_repeat   += a_repeat;
        obs_b_press  += b_press;
        obs_b_repeat += b_repeat;
    endtask

    task automatic clear_obs();
        obs_press = 0; obs_release = 0; obs_repeat = 0;
        obs_b_press = 0; obs_b_repeat = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_level"},   a_level,   0);
        check({tag, "_a_press"},   a_press,   0);
        check({tag, "_a_release"}, a_release, 0);
        check({tag, "_a_repeat"},  a_repeat,  0);
        check({tag, "_a_count"},   a_count,   0);
        check({tag, "_b_level"},   b_level,   0);
        check({tag, "_b_count"},   b_count,   0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;

        // Hand-derived expectations (DEB=4, RD=8, RR=3): pulse counts seen
        // during each segment, level and press_count at its end.
        segs[0]  = '{1'b0, 10, 0, 0, 0, 1'b0, 0};
        segs[1]  = '{1'b1, 40, 1, 0, 9, 1'b1, 1};   // press, repeats 15..39
        segs[2]  = '{1'b0, 12, 0, 1, 1, 1'b0, 1};   // one last repeat, release
        for (int i = 0; i < 5; i++) begin           // press bounce
            segs[3 + 2*i] = '{1'b1, 3, 0, 0, 0, 1'b0, 1};
            segs[4 + 2*i] = '{1'b0, 2, 0, 0, 0, 1'b0, 1};
        end
        segs[13] = '{1'b0, 8,  0, 0, 0, 1'b0, 1};
        segs[14] = '{1'b1, 20, 1, 0, 2, 1'b1, 2};
        segs[15] = '{1'b0, 2,  0, 0, 1, 1'b1, 2};   // release bounce
        segs[16] = '{1'b1, 10, 0, 0, 3, 1'b1, 2};   // repeats shifted by 2
        segs[17] = '{1'b0, 12, 0, 1, 1, 1'b0, 2};

        model_reset();
        clear_obs();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Segment table.
        for (int s = 0; s < c_NSEG; s++) begin
            clear_obs();
            for (int c = 0; c < segs[s].cycles; c++) cycle(segs[s].btn);
            check("seg_press",    obs_press,    segs[s].press);
            check("seg_release",  obs_release,  segs[s].rel);
            check("seg_repeat",   obs_repeat,   segs[s].rep);
            check("seg_b_repeat", obs_b_repeat, 0);
            check("seg_level",    a_level,      segs[s].level);
            check("seg_count",    a_count,      segs[s].count);
        end

        // Asynchronous reset in the middle of a hold.
        for (int c = 0; c < 10; c++) cycle(1'b1);
        check("prereset_level", a_level, 1);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        #1 rst = 1'b0;
        model_reset();
        clear_obs();
        got = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1);
            if (a_press) begin
                got = i;
                break;
            end
        end
        check("press_after_reset_edge", got, 7);
        clear_obs();
        for (int c = 0; c < 12; c++) cycle(1'b0);
        check("post_reset_release", obs_release, 1);

        // Long hold: the REPEAT_DELAY=0 instance must never repeat.
        clear_obs();
        for (int c = 0; c < 100; c++) cycle(1'b1);
        for (int c = 0; c < 12; c++) cycle(1'b0);
        check("rd0_press",    obs_b_press,  1);
        check("rd0_repeat",   obs_b_repeat, 0);
        check("hold100_rep",  obs_repeat,   30);
        check("hold100_cnt",  a_count,      2);

        // Counter wrap: 256 presses since reset bring the count back to 0.
        clear_obs();
        for (int p = 1; p <= 254; p++) begin
            for (int c = 0; c < 8; c++) cycle(1'b1);
            for (int c = 0; c < 8; c++) cycle(1'b0);
            if (p == 253) check("count_255", a_count, 255);
        end
        check("wrap_count",   a_count,   0);
        check("wrap_b_count", b_count,   0);
        check("wrap_presses", obs_press, 254);
        check("wrap_repeats", obs_repeat, 0);

        // Random bouncing against the reference model.
        for (int s = 0; s < 150; s++) begin
            bit b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            for (int c = 0; c < len; c++) cycle(b);
        end
        for (int c = 0; c < 12; c++) cycle(1'b0);
        check("final_level", a_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
